// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM encoding,
// the hard-wired zero register ID and the default divide latency.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_ILLEGAL  = 2'd3
  } ctrl_state_e;

  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam int unsigned DIV_LATENCY_DEF = 32;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// source operands of the instruction in ID.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rs_i,
  input  logic       id_uses_rt_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs_i && (id_rs_i == ex_rd_i);
  assign rt_hit = id_uses_rt_i && (id_rt_i == ex_rd_i);

  // A load into r0 is discarded, so it can never create a hazard.
  assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard controller: memory wait, multi-cycle divide, taken-branch
// flush and load-use interlock. Define STALL_PERF_CNT_EN to add stall_cnt_o.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_uses_rs_i,
  input  logic        id_uses_rt_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_branch_taken_i,
  input  logic        div_start_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        id_ex_stall_o,
  output logic        ex_mem_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic [1:0]  state_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  // The RUN cycle that accepts the divide is the first of DIV_LATENCY stalls.
  localparam logic [7:0] CNT_LOAD = 8'(DIV_LATENCY - 1);

  ctrl_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_hold;
  logic        load_use;
  logic        if_id_flush_raw, id_ex_flush_raw, ex_mem_flush_raw;

  // Memory handshake: mem_req_i marks a pending MEM access; mem_ready_i is
  // the completion strobe. The stage is held only while req=1 and ready=0.
  assign mem_hold = mem_req_i && !mem_ready_i;

  load_use_detect u_load_use_detect (
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_uses_rs_i  (id_uses_rs_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .load_use_o    (load_use)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    pc_stall_o       = 1'b0;
    if_id_stall_o    = 1'b0;
    id_ex_stall_o    = 1'b0;
    ex_mem_stall_o   = mem_hold;
    if_id_flush_raw  = 1'b0;
    id_ex_flush_raw  = 1'b0;
    ex_mem_flush_raw = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_hold) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          state_d       = ST_MEM_WAIT;
        end else if (div_start_i) begin
          pc_stall_o       = 1'b1;
          if_id_stall_o    = 1'b1;
          id_ex_stall_o    = 1'b1;
          ex_mem_flush_raw = 1'b1;
          cnt_d            = CNT_LOAD;
          state_d          = ST_DIV_WAIT;
        end else if (ex_branch_taken_i) begin
          if_id_flush_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end else if (load_use) begin
          pc_stall_o      = 1'b1;
          if_id_stall_o   = 1'b1;
          id_ex_flush_raw = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        pc_stall_o    = mem_hold;
        if_id_stall_o = mem_hold;
        id_ex_stall_o = mem_hold;
        if (!mem_hold) state_d = ST_RUN;
      end

      ST_DIV_WAIT: begin
        pc_stall_o       = 1'b1;
        if_id_stall_o    = 1'b1;
        id_ex_stall_o    = 1'b1;
        ex_mem_flush_raw = !mem_hold;
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        ex_mem_stall_o = 1'b0;
        cnt_d          = '0;
        state_d        = ST_RUN;
      end
    endcase
  end

  // Stall always wins over flush on the same pipeline register.
  assign if_id_flush_o  = if_id_flush_raw  && !if_id_stall_o;
  assign id_ex_flush_o  = id_ex_flush_raw  && !id_ex_stall_o;
  assign ex_mem_flush_o = ex_mem_flush_raw && !ex_mem_stall_o;

  assign state_o = state_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (pc_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: single-cycle RUN vector table
// plus hand sequences for memory wait, divide and reset-during-divide.
module tb_pipeline_stall_controller;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned LAT = 4;

  // Output bit order: {pc, if_id, id_ex, ex_mem stall, if_id, id_ex, ex_mem flush}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100010;
  localparam logic [6:0] O_BR   = 7'b0000110;
  localparam logic [6:0] O_DIV  = 7'b1110001;
  localparam logic [6:0] O_MEM  = 7'b1111000;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [4:0] id_rs_i, id_rt_i, ex_rd_i;
  logic       id_uses_rs_i, id_uses_rt_i, ex_mem_read_i;
  logic       ex_branch_taken_i, div_start_i, mem_req_i, mem_ready_i;
  logic       pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o;
  logic       if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
  logic [1:0] state_o;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] model_cnt = '0;
`endif

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       urs, urt, mrd, br, dv, mreq, mrdy;
    logic [6:0] exp_out;
  } vec_t;

  vec_t vq[$];

  pipeline_stall_controller #(.DIV_LATENCY(LAT)) dut (
    .sys_clk           (sys_clk),
    .rst_n             (rst_n),
    .id_rs_i           (id_rs_i),
    .id_rt_i           (id_rt_i),
    .id_uses_rs_i      (id_uses_rs_i),
    .id_uses_rt_i      (id_uses_rt_i),
    .ex_mem_read_i     (ex_mem_read_i),
    .ex_rd_i           (ex_rd_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .div_start_i       (div_start_i),
    .mem_req_i         (mem_req_i),
    .mem_ready_i       (mem_ready_i),
    .pc_stall_o        (pc_stall_o),
    .if_id_stall_o     (if_id_stall_o),
    .id_ex_stall_o     (id_ex_stall_o),
    .ex_mem_stall_o    (ex_mem_stall_o),
    .if_id_flush_o     (if_id_flush_o),
    .id_ex_flush_o     (id_ex_flush_o),
    .ex_mem_flush_o    (ex_mem_flush_o),
    .state_o           (state_o)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cnt_o       (stall_cnt_o)
`endif
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  // Driver tasks
  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mrd, input logic [4:0] rd,
                        input logic br, input logic dv, input logic mreq, input logic mrdy);
    id_rs_i = rs; id_rt_i = rt; id_uses_rs_i = urs; id_uses_rt_i = urt;
    ex_mem_read_i = mrd; ex_rd_i = rd; ex_branch_taken_i = br;
    div_start_i = dv; mem_req_i = mreq; mem_ready_i = mrdy;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_vec(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic mrd, input logic [4:0] rd,
                         input logic br, input logic mreq, input logic mrdy,
                         input logic [6:0] eo);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mrd = mrd; v.rd = rd;
    v.br = br; v.dv = 1'b0; v.mreq = mreq; v.mrdy = mrdy; v.exp_out = eo;
    vq.push_back(v);
  endtask

  // Scoreboard: inputs are already applied (posedge+1); sample at posedge+4,
  // then advance to the next posedge+1.
  task automatic check_cycle(input string name, input logic [6:0] eo, input logic [1:0] es);
    logic [8:0] got, exp;
    #3;
    exp_q.push_back({es, eo});
    got = {state_o, pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: state_outs got %b_%b required %b_%b", name,
               got[8:7], got[6:0], exp[8:7], exp[6:0]);
    end
`ifdef STALL_PERF_CNT_EN
    checks++;
    if (stall_cnt_o !== model_cnt) begin
      failures++;
      $display("FAIL %s_perf: stall_cnt got %0d required %0d", name, stall_cnt_o, model_cnt);
    end
    if (eo[6] && rst_n) model_cnt = model_cnt + 32'd1;
`endif
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    idle();
    check_cycle("reset", O_NONE, ST_RUN);
    rst_n = 1'b1;
    check_cycle("idle_after_reset", O_NONE, ST_RUN);

    // Single-cycle vectors, all evaluated in RUN.
    add_vec(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, O_LU);    // load-use on rs
    add_vec(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, O_NONE);  // load to r0: no hazard
    add_vec(5'd1, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0, O_LU);    // load-use on rt
    add_vec(5'd1, 5'd7, 1, 0, 1, 5'd7, 0, 0, 0, O_NONE);  // rt matches but unused
    add_vec(5'd9, 5'd0, 1, 0, 0, 5'd9, 0, 0, 0, O_NONE);  // not a load
    add_vec(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, O_BR);    // branch beats load-use
    add_vec(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, O_BR);    // branch alone
    add_vec(5'd3, 5'd3, 1, 1, 1, 5'd3, 0, 1, 1, O_LU);    // mem ready same cycle: no hold
    add_vec(5'd4, 5'd6, 1, 1, 1, 5'd5, 0, 0, 0, O_NONE);  // no register match
    add_vec(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_NONE);  // completed access alone
    for (int i = 0; i < vq.size(); i++) begin
      set_in(vq[i].rs, vq[i].rt, vq[i].urs, vq[i].urt, vq[i].mrd, vq[i].rd,
             vq[i].br, vq[i].dv, vq[i].mreq, vq[i].mrdy);
      check_cycle($sformatf("vec%0d", i), vq[i].exp_out, ST_RUN);
    end

    // Memory wait: 3 held cycles, divide ignored in MEM_WAIT, release on ready.
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0);
    check_cycle("mem_hold_run", O_MEM, ST_RUN);
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0);
    check_cycle("mem_wait_div_ignored", O_MEM, ST_MEM_WAIT);
    set_in(5'd2, 5'd0, 1, 0, 1, 5'd2, 1, 0, 1, 0);
    check_cycle("mem_wait_br_lu_ignored", O_MEM, ST_MEM_WAIT);
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1);
    check_cycle("mem_ready", O_NONE, ST_MEM_WAIT);
    idle();
    check_cycle("mem_back_run", O_NONE, ST_RUN);

    // Divide: exactly LAT stall cycles with EX/MEM flushed each.
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0);
    check_cycle("div_start", O_DIV, ST_RUN);
    idle();
    check_cycle("div_wait1", O_DIV, ST_DIV_WAIT);
    set_in(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 0);
    check_cycle("div_wait2_br_ignored", O_DIV, ST_DIV_WAIT);
    idle();
    check_cycle("div_wait3", O_DIV, ST_DIV_WAIT);
    check_cycle("div_done", O_NONE, ST_RUN);

    // mem_hold beats divide in RUN.
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0);
    check_cycle("mem_over_div", O_MEM, ST_RUN);
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1);
    check_cycle("mem_over_div_ready", O_NONE, ST_MEM_WAIT);

    // Divide with a memory hold mid-wait: EX/MEM stalls instead of flushing.
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0);
    check_cycle("div2_start", O_DIV, ST_RUN);
    idle();
    check_cycle("div2_wait1", O_DIV, ST_DIV_WAIT);
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0);
    check_cycle("div2_wait2_memhold", O_MEM, ST_DIV_WAIT);
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1);
    check_cycle("div2_wait3", O_DIV, ST_DIV_WAIT);
    idle();
    check_cycle("div2_done", O_NONE, ST_RUN);

    // Reset in the middle of a divide abandons it.
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0);
    check_cycle("rdiv_start", O_DIV, ST_RUN);
    idle();
    check_cycle("rdiv_wait1", O_DIV, ST_DIV_WAIT);
    rst_n = 1'b0;
`ifdef STALL_PERF_CNT_EN
    model_cnt = '0;
`endif
    check_cycle("rdiv_in_reset", O_NONE, ST_RUN);
    rst_n = 1'b1;
    set_in(5'd6, 5'd0, 1, 0, 1, 5'd6, 0, 0, 0, 0);
    check_cycle("rdiv_release_lu", O_LU, ST_RUN);
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0);
    check_cycle("rdiv2_start", O_DIV, ST_RUN);
    idle();
    check_cycle("rdiv2_wait1", O_DIV, ST_DIV_WAIT);
    check_cycle("rdiv2_wait2", O_DIV, ST_DIV_WAIT);
    check_cycle("rdiv2_wait3", O_DIV, ST_DIV_WAIT);
    check_cycle("rdiv2_done", O_NONE, ST_RUN);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
